// File: rtl/rtype_issue_stage.sv
// RV32I R-type issue stage: decodes funct7/funct3 into an ALU select, reads two
// operands from a 32x32 register file with write-back bypass, and holds the result in a one-entry skid register.
module rtype_issue_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [3:0]       ALU_sel,
  output logic [XLEN-1:0]  reg1,
  output logic [XLEN-1:0]  reg2,
  output logic [4:0]       rd_addr,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            legal;
  logic [3:0]      sel;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            accept;
  logic            leave;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Handshake: a transfer happens on a rising edge where valid && ready. The
  // output register accepts a new instruction whenever it is empty or its
  // current bundle is leaving in the same cycle, so accept+leave is allowed.
  assign instr_ready = !issue_valid || issue_ready;
  assign accept      = instr_valid && instr_ready;
  assign leave       = issue_valid && issue_ready;

  always_comb begin
    legal = 1'b0;
    sel   = 4'd0;
    if (opcode == OP_RTYPE) begin
      case ({funct7, funct3})
        {7'b0000000, 3'b000}: begin legal = 1'b1; sel = 4'd0; end
        {7'b0100000, 3'b000}: begin legal = 1'b1; sel = 4'd1; end
        {7'b0000000, 3'b001}: begin legal = 1'b1; sel = 4'd2; end
        {7'b0000000, 3'b010}: begin legal = 1'b1; sel = 4'd3; end
        {7'b0000000, 3'b011}: begin legal = 1'b1; sel = 4'd4; end
        {7'b0000000, 3'b100}: begin legal = 1'b1; sel = 4'd5; end
        {7'b0000000, 3'b101}: begin legal = 1'b1; sel = 4'd6; end
        {7'b0100000, 3'b101}: begin legal = 1'b1; sel = 4'd7; end
        {7'b0000000, 3'b110}: begin legal = 1'b1; sel = 4'd8; end
        {7'b0000000, 3'b111}: begin legal = 1'b1; sel = 4'd9; end
        default:              begin legal = 1'b0; sel = 4'd0; end
      endcase
    end
  end

  // x0 reads as zero; a nonzero index matching a same-cycle write-back takes
  // the incoming value instead of the stale array entry.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) begin
      if (wb_valid && (wb_addr == rs1)) rs1_val = wb_data;
      else                              rs1_val = regs[rs1];
    end
    if (rs2 != 5'd0) begin
      if (wb_valid && (wb_addr == rs2)) rs2_val = wb_data;
      else                              rs2_val = regs[rs2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_valid && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      ALU_sel     <= 4'd0;
      reg1        <= '0;
      reg2        <= '0;
      rd_addr     <= 5'd0;
    end else if (accept && legal) begin
      issue_valid <= 1'b1;
      ALU_sel     <= sel;
      reg1        <= rs1_val;
      reg2        <= rs2_val;
      rd_addr     <= rd;
    end else if (leave) begin
      // Covers an illegal accept too: it can only happen when empty or leaving.
      issue_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else begin
      illegal <= accept && !legal;
      if (accept && !legal && (illegal_count != {CNT_W{1'b1}}))
        illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rtype_issue_stage.sv
// Directed bench for rtype_issue_stage: decode table, bypass, stall/back-to-back,
// illegal counting with saturation, and reset dominance.
module tb_rtype_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  ALU_sel;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  rd_addr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [7:0]  illegal_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_cnt      = 0;

  logic [73:0] bundle;
  logic [73:0] exp_b;
  logic [73:0] held_b;

  rtype_issue_stage #(.XLEN(32), .NREGS(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ALU_sel(ALU_sel), .reg1(reg1), .reg2(reg2), .rd_addr(rd_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  assign bundle = {issue_valid, ALU_sel, reg1, reg2, rd_addr};

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_cnt();
    if (exp_cnt < 255) exp_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0; issue_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    tests_run++;
    if (bundle !== 74'd0) begin tests_failed++; $display("FAIL reset_bundle got=%h exp=0", bundle); end
    tests_run++;
    if ({illegal, illegal_count} !== 9'd0) begin tests_failed++; $display("FAIL reset_illegal got=%b/%0d exp=0/0", illegal, illegal_count); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
  endtask

  task automatic test_add();
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'd1;  tick();
    wb_addr = 5'd2; wb_data = 32'd22; tick();
    wb_valid = 1'b0;
    instr = 32'h002081B3; instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    exp_b = {1'b1, 4'd0, 32'd1, 32'd22, 5'd3};
    tests_run++;
    if (bundle !== exp_b) begin tests_failed++; $display("FAIL add_bundle got=%h exp=%h", bundle, exp_b); end
    tick();
    tests_run++;
    if (issue_valid !== 1'b0) begin tests_failed++; $display("FAIL add_drain got=%b exp=0", issue_valid); end
  endtask

  task automatic test_bypass();
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'd5; tick();
    wb_addr = 5'd7; wb_data = 32'hFFFF_FFFF;
    instr = 32'h407302B3; instr_valid = 1'b1; tick();
    wb_valid = 1'b0;
    exp_b = {1'b1, 4'd1, 32'd5, 32'hFFFF_FFFF, 5'd5};
    tests_run++;
    if (bundle !== exp_b) begin tests_failed++; $display("FAIL bypass_sub got=%h exp=%h", bundle, exp_b); end
    instr = rtype(7'd0, 5'd0, 5'd7, 3'b000, 5'd8); tick();
    instr_valid = 1'b0;
    exp_b = {1'b1, 4'd0, 32'hFFFF_FFFF, 32'd0, 5'd8};
    tests_run++;
    if (bundle !== exp_b) begin tests_failed++; $display("FAIL bypass_written got=%h exp=%h", bundle, exp_b); end
    tick();
  endtask

  task automatic test_stall();
    issue_ready = 1'b0;
    instr = rtype(7'd0, 5'd2, 5'd1, 3'b110, 5'd8); instr_valid = 1'b1; tick();
    held_b = {1'b1, 4'd8, 32'd1, 32'd22, 5'd8};
    instr = rtype(7'd0, 5'd1, 5'd2, 3'b100, 5'd9);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready[%0d] got=%b exp=0", k, instr_ready); end
      tests_run++;
      if (bundle !== held_b) begin tests_failed++; $display("FAIL stall_hold[%0d] got=%h exp=%h", k, bundle, held_b); end
      if (k == 0) begin wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'd100; end
      tick();
      wb_valid = 1'b0;
    end
    tests_run++;
    if (bundle !== held_b) begin tests_failed++; $display("FAIL stall_hold_after_wb got=%h exp=%h", bundle, held_b); end
    issue_ready = 1'b1;
    #1;
    tests_run++;
    if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL release_ready got=%b exp=1", instr_ready); end
    tick();
    exp_b = {1'b1, 4'd5, 32'd22, 32'd100, 5'd9};
    tests_run++;
    if (bundle !== exp_b) begin tests_failed++; $display("FAIL release_xor got=%h exp=%h", bundle, exp_b); end
    instr = rtype(7'd0, 5'd1, 5'd1, 3'b001, 5'd10); tick();
    instr_valid = 1'b0;
    exp_b = {1'b1, 4'd2, 32'd100, 32'd100, 5'd10};
    tests_run++;
    if (bundle !== exp_b) begin tests_failed++; $display("FAIL b2b_sll got=%h exp=%h", bundle, exp_b); end
    tick();
    tests_run++;
    if (issue_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got=%b exp=0", issue_valid); end
  endtask

  task automatic test_decode();
    logic [6:0] f7_t  [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0] f3_t  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [3:0] sel_t [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                              4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
    logic [9:0] got;
    logic [9:0] exp;
    issue_ready = 1'b1; instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = rtype(f7_t[i], 5'd2, 5'd1, f3_t[i], 5'(i + 1));
      tick();
      got = {issue_valid, illegal, ALU_sel, rd_addr[3:0]};
      exp = {1'b1, 1'b0, sel_t[i], 4'(i + 1)};
      tests_run++;
      if (got !== exp) begin tests_failed++; $display("FAIL decode[%0d] got=%b exp=%b", i, got, exp); end
    end
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_DEAD; tick();
    instr = 32'h000070B3; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; wb_valid = 1'b0;
    exp_b = {1'b1, 4'b1001, 32'd0, 32'd0, 5'd1};
    tests_run++;
    if (bundle !== exp_b) begin tests_failed++; $display("FAIL x0_and got=%h exp=%h", bundle, exp_b); end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] bad_t [3];
    bad_t[0] = rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3);
    bad_t[1] = rtype(7'b0100000, 5'd2, 5'd1, 3'b001, 5'd3);
    bad_t[2] = rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3) | 32'h4;
    instr = 32'h0000_0013; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; bump_cnt();
    tests_run++;
    if ({issue_valid, illegal, illegal_count} !== {1'b0, 1'b1, 8'(exp_cnt)}) begin
      tests_failed++; $display("FAIL addi_pulse got=%b/%b/%0d exp=0/1/%0d", issue_valid, illegal, illegal_count, exp_cnt);
    end
    tick();
    tests_run++;
    if ({illegal, illegal_count} !== {1'b0, 8'(exp_cnt)}) begin
      tests_failed++; $display("FAIL addi_pulse_end got=%b/%0d exp=0/%0d", illegal, illegal_count, exp_cnt);
    end
    instr = 32'h002081B3; instr_valid = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      instr = bad_t[i]; tick(); bump_cnt();
      tests_run++;
      if ({issue_valid, illegal, illegal_count} !== {1'b0, 1'b1, 8'(exp_cnt)}) begin
        tests_failed++; $display("FAIL bad[%0d] got=%b/%b/%0d exp=0/1/%0d", i, issue_valid, illegal, illegal_count, exp_cnt);
      end
    end
    instr = 32'h0000_0013;
    for (int i = 0; i < 300; i++) begin
      tick(); bump_cnt();
    end
    instr_valid = 1'b0;
    tests_run++;
    if ({illegal, illegal_count} !== {1'b1, 8'd255}) begin
      tests_failed++; $display("FAIL saturate got=%b/%0d exp=1/255", illegal, illegal_count);
    end
    tick();
    tests_run++;
    if ({issue_valid, illegal, illegal_count} !== {1'b0, 1'b0, 8'd255}) begin
      tests_failed++; $display("FAIL saturate_hold got=%b/%b/%0d exp=0/0/255", issue_valid, illegal, illegal_count);
    end
  endtask

  task automatic test_reset_dominance();
    issue_ready = 1'b0;
    instr = 32'h002081B3; instr_valid = 1'b1; tick();
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h1234; tick();
    rst = 1'b0; wb_valid = 1'b0; instr_valid = 1'b0;
    tests_run++;
    if (bundle !== 74'd0) begin tests_failed++; $display("FAIL rst_dom_bundle got=%h exp=0", bundle); end
    tests_run++;
    if ({illegal, illegal_count} !== 9'd0) begin tests_failed++; $display("FAIL rst_dom_count got=%b/%0d exp=0/0", illegal, illegal_count); end
    issue_ready = 1'b1;
    instr = rtype(7'd0, 5'd10, 5'd10, 3'b000, 5'd11); instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    exp_b = {1'b1, 4'd0, 32'd0, 32'd0, 5'd11};
    tests_run++;
    if (bundle !== exp_b) begin tests_failed++; $display("FAIL rst_dom_read got=%h exp=%h", bundle, exp_b); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_stall();
    test_decode();
    test_x0();
    test_illegal();
    test_reset_dominance();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rtype_issue_stage.md
Name: rtype_issue_stage

Overview:
- Upstream neighbour of the ALU in the RV32I R-type datapath.
- Accepts a 32-bit instruction over a valid/ready handshake, decodes opcode/funct3/funct7 into the 4-bit ALU select, and reads two operands from an internal 32x32 register file with write-back bypass.
- Presents the ALU_sel/reg1/reg2 bundle plus destination register through a one-entry output register with its own valid/ready handshake.
- Write-back of ALU_Out returns to this block.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, architectural register count (x0 hardwired to zero)
- CNT_W, 8, width of saturating illegal-instruction counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  stage can accept instruction this cycle
- instr  in  32  RV32I instruction word
- issue_valid  out  1  output bundle valid
- issue_ready  in  1  ALU side consumes bundle
- ALU_sel  out  4  ALU operation select
- reg1  out  XLEN  rs1 operand
- reg2  out  XLEN  rs2 operand
- rd_addr  out  5  destination register
- wb_valid  in  1  write-back strobe
- wb_addr  in  5  write-back register
- wb_data  in  XLEN  write-back value (ALU_Out)
- illegal  out  1  one-cycle pulse on rejected instruction
- illegal_count  out  CNT_W  saturating count of rejected instructions

Behaviour:
- Reset (rst=1 at edge):
  - issue_valid=0, ALU_sel=0, reg1=0, reg2=0, rd_addr=0, illegal=0, illegal_count=0.
  - All 32 registers cleared to 0.
  - rst dominates any accept or write-back in the same cycle.
- Handshake:
  - instr_ready = !issue_valid || issue_ready (combinational).
  - Accept when instr_valid && instr_ready.
  - Bundle leaves when issue_valid && issue_ready.
  - Accept and leave in the same cycle are allowed, giving full throughput of 1 instruction/cycle.
- Latency: accepted instruction appears on issue_valid/bundle at the next edge (1 cycle).
- Stall: while issue_valid && !issue_ready, ALU_sel/reg1/reg2/rd_addr are held stable and instr_ready=0.
- Legality: legal only when opcode=0110011 and the funct7/funct3 pair is in the decode table. Anything else is illegal.
- Decode (funct7, funct3 -> ALU_sel):
  - 0000000,000 ADD 0000
  - 0100000,000 SUB 0001
  - 0000000,001 SLL 0010
  - 0000000,010 SLT 0011
  - 0000000,011 SLTU 0100
  - 0000000,100 XOR 0101
  - 0000000,101 SRL 0110
  - 0100000,101 SRA 0111
  - 0000000,110 OR 1000
  - 0000000,111 AND 1001
- Illegal accept:
  - Instruction is consumed (no retry).
  - No bundle is produced; issue_valid is cleared if the previous bundle left this cycle.
  - illegal=1 for exactly the next cycle.
  - illegal_count increments, saturating at 2^CNT_W-1.
- Register file:
  - Read index 0 returns 0.
  - Write when wb_valid && wb_addr!=0; writes to x0 are ignored.
- Bypass: on accept, if wb_valid && wb_addr!=0 && wb_addr==rs1 (or rs2), that operand takes wb_data instead of the stale array value. rs1==rs2 bypasses both.
- Write-back is independent of handshake state; it may occur during a stall. A held bundle is not updated by a later write-back.
- rd_addr passes instr[11:7] unmodified, including rd=0.

Test Plan:
- Reset then write-back x1=1, x2=22; issue ADD x3,x1,x2 (0x002081B3) -> next cycle issue_valid=1, ALU_sel=0000, reg1=1, reg2=22, rd_addr=3.
- SUB x5,x6,x7 (0x407302B3) issued in the same cycle as wb x7=0xFFFFFFFF -> reg2=0xFFFFFFFF (bypass), ALU_sel=0001.
- Hold issue_ready=0 for 3 cycles with instr_valid=1 -> instr_ready=0, bundle stable. Release -> next instruction accepted the same cycle, back-to-back issue.
- Instruction 0x00000013 (ADDI) -> no issue_valid, illegal pulses 1 cycle, illegal_count=1. Drive 300 illegals -> count saturates at 255.
- wb_addr=0, wb_data=0xDEAD; then issue AND x1,x0,x0 -> reg1=0, reg2=0, ALU_sel=1001.
- Assert rst while bundle held and wb_valid=1 -> next cycle issue_valid=0, all outputs 0, and a subsequent read of the written register returns 0.
